mem_port_arbiter: RTL and testbench

- Shares the single physical memory port of the 1-port rv32 core between the instruction-fetch requester (I) and the data load/store requester (D).
- Sits between the core datapath/control path and the memory.
- Sequences one outstanding transaction at a time.
- Produces the per-requester miss signals that feed the control path's imiss/stall logic.
- Prevents fetch starvation with a bounded data-priority streak.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/arb_streak_picker.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
//   arb_state_e     : arbiter FSM state encoding
//   FCN_LOAD/STORE  : memory function codes
//   MT_W            : word access size code used for instruction fetches
//   STREAK_W/TIMER_W: widths of the streak counter and the response timer
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReqI  = 3'd1,
    StWaitI = 3'd2,
    StReqD  = 3'd3,
    StWaitD = 3'd4
  } arb_state_e;

  localparam logic       FCN_LOAD  = 1'b0;
  localparam logic       FCN_STORE = 1'b1;
  localparam logic [2:0] MT_W      = 3'h3;

  localparam int unsigned STREAK_W = 4;
  localparam int unsigned TIMER_W  = 8;

endpackage

// File: rtl/arb_streak_picker.sv
// Priority picker between the fetch (I) and data (D) requesters with a
// saturating D-streak counter that bounds how long a waiting fetch can starve.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_i_valid      : fetch requester valid
//   i_d_valid      : data requester valid
//   i_take         : the current pick is being granted this cycle
//   o_pick_i       : fetch wins arbitration
//   o_pick_d       : data wins arbitration
module arb_streak_picker
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_i_valid,
  input  logic i_d_valid,
  input  logic i_take,
  output logic o_pick_i,
  output logic o_pick_d
);

  localparam logic [STREAK_W-1:0] MaxStreak = STREAK_W'(MAX_STREAK);

  logic [STREAK_W-1:0] r_streak;
  logic                w_i_starved;

  // D normally wins; once it has won MaxStreak times in a row over a
  // waiting fetch, the fetch gets the next grant.
  assign w_i_starved = i_i_valid && (r_streak == MaxStreak);
  assign o_pick_d    = i_d_valid && !w_i_starved;
  assign o_pick_i    = i_i_valid && !o_pick_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_streak <= '0;
    end else if (i_take) begin
      if (o_pick_d && i_i_valid) begin
        if (r_streak != MaxStreak) begin
          r_streak <= r_streak + 1'b1;
        end
      end else begin
        r_streak <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port of the 1-port rv32 core between instruction
// fetch (I) and data load/store (D), one outstanding transaction at a time.
// Ports:
//   clock, reset          : core clock, synchronous active-low reset
//   i_req_* / i_resp_*    : fetch request/response handshake
//   d_req_* / d_resp_*    : data request/response handshake
//   mem_req_* / mem_resp_*: physical memory port
//   imiss, dmiss          : requester valid with no response this cycle
//   timeout_err           : sticky flag, memory failed to respond in time
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned MAX_D_STREAK   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_req_valid,
  input  logic [XLEN-1:0] i_req_addr,
  output logic            i_req_ready,
  output logic            i_resp_valid,
  output logic [XLEN-1:0] i_resp_data,
  input  logic            d_req_valid,
  input  logic [XLEN-1:0] d_req_addr,
  input  logic [XLEN-1:0] d_req_wdata,
  input  logic            d_req_fcn,
  input  logic [2:0]      d_req_typ,
  output logic            d_req_ready,
  output logic            d_resp_valid,
  output logic [XLEN-1:0] d_resp_data,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic            mem_req_fcn,
  output logic [2:0]      mem_req_typ,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            imiss,
  output logic            dmiss,
  output logic            timeout_err
);

  localparam logic [TIMER_W-1:0] TimeoutLim = TIMER_W'(TIMEOUT_CYCLES);

  arb_state_e        r_state;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic              r_fcn;
  logic [2:0]        r_typ;
  logic [TIMER_W-1:0] r_timer;
  logic              r_timeout_err;

  logic w_idle;
  logic w_take;
  logic w_pick_i;
  logic w_pick_d;
  logic w_grant_i;
  logic w_grant_d;
  logic w_wait_i;
  logic w_wait_d;
  logic w_tmo_hit;
  logic w_wait_done;

  assign w_idle = (r_state == StIdle);
  // Grants are held off while reset is asserted so no requester sees a
  // handshake that the reset is about to discard.
  assign w_take    = reset && w_idle && (i_req_valid || d_req_valid);
  assign w_grant_i = w_take && w_pick_i;
  assign w_grant_d = w_take && w_pick_d;

  arb_streak_picker #(
    .MAX_STREAK (MAX_D_STREAK)
  ) u_picker (
    .i_clk     (clock),
    .i_rst_n   (reset),
    .i_i_valid (i_req_valid),
    .i_d_valid (d_req_valid),
    .i_take    (w_take),
    .o_pick_i  (w_pick_i),
    .o_pick_d  (w_pick_d)
  );

  // r_timer counts completed WAIT cycles; the cycle in which it reads the
  // limit is the last one a response is accepted as normal.
  assign w_wait_i    = (r_state == StWaitI);
  assign w_wait_d    = (r_state == StWaitD);
  assign w_tmo_hit   = (r_timer == TimeoutLim);
  assign w_wait_done = mem_resp_valid || w_tmo_hit;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= StIdle;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_fcn         <= FCN_LOAD;
      r_typ         <= '0;
      r_timer       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_grant_i) begin
            r_state <= StReqI;
            r_addr  <= i_req_addr;
            r_wdata <= '0;
            r_fcn   <= FCN_LOAD;
            r_typ   <= MT_W;
          end else if (w_grant_d) begin
            r_state <= StReqD;
            r_addr  <= d_req_addr;
            r_wdata <= d_req_wdata;
            r_fcn   <= d_req_fcn;
            r_typ   <= d_req_typ;
          end
        end
        StReqI: begin
          if (mem_req_ready) begin
            r_state <= StWaitI;
            r_timer <= '0;
          end
        end
        StReqD: begin
          if (mem_req_ready) begin
            r_state <= StWaitD;
            r_timer <= '0;
          end
        end
        StWaitI, StWaitD: begin
          if (mem_resp_valid) begin
            r_state <= StIdle;
          end else if (w_tmo_hit) begin
            r_state       <= StIdle;
            r_timeout_err <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign i_req_ready = w_grant_i;
  assign d_req_ready = w_grant_d;

  assign mem_req_valid = (r_state == StReqI) || (r_state == StReqD);
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;
  assign mem_req_fcn   = r_fcn;
  assign mem_req_typ   = r_typ;

  // On timeout the waiting requester still gets a pulse, with zero data.
  assign i_resp_valid = w_wait_i && w_wait_done;
  assign d_resp_valid = w_wait_d && w_wait_done;
  assign i_resp_data  = (w_wait_i && mem_resp_valid) ? mem_resp_data : '0;
  assign d_resp_data  = (w_wait_d && mem_resp_valid) ? mem_resp_data : '0;

  assign imiss       = i_req_valid && !i_resp_valid;
  assign dmiss       = d_req_valid && !d_resp_valid;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grants,
// memory requests and responses into queues; a monitor pops and compares.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        fcn;
    logic [2:0]  typ;
  } mreq_t;

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } resp_t;

  logic        clock, reset;
  logic        i_req_valid, i_req_ready, i_resp_valid;
  logic [31:0] i_req_addr, i_resp_data;
  logic        d_req_valid, d_req_fcn, d_req_ready, d_resp_valid;
  logic [31:0] d_req_addr, d_req_wdata, d_resp_data;
  logic [2:0]  d_req_typ;
  logic        mem_req_valid, mem_req_ready, mem_req_fcn, mem_resp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_data;
  logic [2:0]  mem_req_typ;
  logic        imiss, dmiss, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int resp_cnt = 0;
  int d_resp_cnt = 0;

  bit    q_grant[$];
  mreq_t q_mreq[$];
  resp_t q_resp[$];

  bit          mem_auto;
  logic        m_acc, m_fcn;
  logic [31:0] m_addr;
  bit          g;
  mreq_t       em;
  resp_t       er;
  int          base, d0;

  mem_port_arbiter #(
    .XLEN           (32),
    .MAX_D_STREAK   (4),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .i_req_valid    (i_req_valid),
    .i_req_addr     (i_req_addr),
    .i_req_ready    (i_req_ready),
    .i_resp_valid   (i_resp_valid),
    .i_resp_data    (i_resp_data),
    .d_req_valid    (d_req_valid),
    .d_req_addr     (d_req_addr),
    .d_req_wdata    (d_req_wdata),
    .d_req_fcn      (d_req_fcn),
    .d_req_typ      (d_req_typ),
    .d_req_ready    (d_req_ready),
    .d_resp_valid   (d_resp_valid),
    .d_resp_data    (d_resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_fcn    (mem_req_fcn),
    .mem_req_typ    (mem_req_typ),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .imiss          (imiss),
    .dmiss          (dmiss),
    .timeout_err    (timeout_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] md(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got unexpected event, required none", name);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_resp(input int target, input int budget);
    int n;
    n = 0;
    while (resp_cnt < target && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("resp_wait_budget", 32'(resp_cnt >= target), 32'd1);
  endtask

  task automatic push(input bit is_d, input logic [31:0] a, input logic [31:0] wd,
                      input logic f, input logic [2:0] t, input bit want_resp,
                      input logic [31:0] rdata);
    mreq_t m;
    resp_t r;
    m = '{addr: a, wdata: wd, fcn: f, typ: t};
    r = '{is_d: is_d, data: rdata};
    q_grant.push_back(is_d);
    q_mreq.push_back(m);
    if (want_resp) q_resp.push_back(r);
  endtask

  // Memory model: one-cycle response after acceptance; zero data for stores.
  initial begin
    forever begin
      @(negedge clock);
      m_acc  = mem_req_valid && mem_req_ready;
      m_addr = mem_req_addr;
      m_fcn  = mem_req_fcn;
      @(posedge clock);
      #1;
      if (mem_auto) begin
        mem_resp_valid = m_acc;
        mem_resp_data  = (m_acc && !m_fcn) ? md(m_addr) : 32'h0;
      end
    end
  end

  // Monitor: every handshake the DUT presents is checked against the queues.
  initial begin
    forever begin
      @(negedge clock);
      if (i_req_ready && d_req_ready) fail_evt("dual_grant");
      if (i_req_ready || d_req_ready) begin
        if (q_grant.size() == 0) fail_evt("unexpected_grant");
        else begin
          g = q_grant.pop_front();
          chk("grant_is_d", 32'(d_req_ready), 32'(g));
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        if (q_mreq.size() == 0) fail_evt("unexpected_mem_req");
        else begin
          em = q_mreq.pop_front();
          chk("mem_req_addr", mem_req_addr, em.addr);
          chk("mem_req_wdata", mem_req_wdata, em.wdata);
          chk("mem_req_fcn", 32'(mem_req_fcn), 32'(em.fcn));
          chk("mem_req_typ", 32'(mem_req_typ), 32'(em.typ));
        end
      end
      if (i_resp_valid && d_resp_valid) fail_evt("dual_resp");
      if (i_resp_valid || d_resp_valid) begin
        if (d_resp_valid) d_resp_cnt++;
        if (q_resp.size() == 0) fail_evt("unexpected_resp");
        else begin
          er = q_resp.pop_front();
          chk("resp_is_d", 32'(d_resp_valid), 32'(er.is_d));
          chk("resp_data", d_resp_valid ? d_resp_data : i_resp_data, er.data);
        end
        resp_cnt++;
      end
    end
  end

  initial begin
    reset = 1'b0; mem_auto = 1'b1; mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    i_req_valid = 1'b0; i_req_addr = 32'h0;
    d_req_valid = 1'b0; d_req_addr = 32'h0; d_req_wdata = 32'h0;
    d_req_fcn = 1'b0; d_req_typ = 3'h0;
    repeat (2) tick;

    // Reset values, with both requesters asserting to show grants are held off.
    i_req_valid = 1'b1; d_req_valid = 1'b1;
    @(negedge clock);
    chk("rst_i_ready", 32'(i_req_ready), 32'd0);
    chk("rst_d_ready", 32'(d_req_ready), 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_req_addr", mem_req_addr, 32'h0);
    chk("rst_i_resp_valid", 32'(i_resp_valid), 32'd0);
    chk("rst_d_resp_valid", 32'(d_resp_valid), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    tick;
    i_req_valid = 1'b0; d_req_valid = 1'b0; reset = 1'b1;
    tick;

    // Fetch only: ready cycle 0, mem request cycle 1, response cycle 2.
    push(1'b0, 32'h100, 32'h0, 1'b0, 3'h3, 1'b1, md(32'h100));
    i_req_valid = 1'b1; i_req_addr = 32'h100;
    @(negedge clock);
    chk("f_c0_i_ready", 32'(i_req_ready), 32'd1);
    chk("f_c0_imiss", 32'(imiss), 32'd1);
    tick;
    @(negedge clock);
    chk("f_c1_mem_req_valid", 32'(mem_req_valid), 32'd1);
    chk("f_c1_imiss", 32'(imiss), 32'd1);
    tick;
    @(negedge clock);
    chk("f_c2_i_resp_valid", 32'(i_resp_valid), 32'd1);
    chk("f_c2_i_resp_data", i_resp_data, md(32'h100));
    chk("f_c2_imiss", 32'(imiss), 32'd0);
    tick;
    i_req_valid = 1'b0;
    tick;

    // Both valid: D,D,D,D,I,D,D,D,D,I.
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) push(1'b0, 32'h200, 32'h0, 1'b0, 3'h3, 1'b1, md(32'h200));
      else push(1'b1, 32'h3000, 32'h0, 1'b0, 3'h2, 1'b1, md(32'h3000));
    end
    base = resp_cnt;
    i_req_valid = 1'b1; i_req_addr = 32'h200;
    d_req_valid = 1'b1; d_req_addr = 32'h3000; d_req_wdata = 32'h0;
    d_req_fcn = 1'b0; d_req_typ = 3'h2;
    wait_resp(base + 10, 100);
    tick;
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    tick;

    // Store, valid dropped right after the grant.
    push(1'b1, 32'h2000, 32'hDEADBEEF, 1'b1, 3'h2, 1'b1, 32'h0);
    base = resp_cnt; d0 = d_resp_cnt;
    d_req_valid = 1'b1; d_req_addr = 32'h2000; d_req_wdata = 32'hDEADBEEF;
    d_req_fcn = 1'b1; d_req_typ = 3'h2;
    @(negedge clock);
    chk("st_d_ready", 32'(d_req_ready), 32'd1);
    tick;
    d_req_valid = 1'b0; d_req_wdata = 32'h0; d_req_fcn = 1'b0;
    wait_resp(base + 1, 10);
    repeat (3) tick;
    chk("st_resp_once", 32'(d_resp_cnt - d0), 32'd1);

    // Memory back-pressure for 5 cycles; fields must stay stable.
    push(1'b0, 32'h400, 32'h0, 1'b0, 3'h3, 1'b1, md(32'h400));
    i_req_valid = 1'b1; i_req_addr = 32'h400;
    @(negedge clock);
    chk("bp_i_ready", 32'(i_req_ready), 32'd1);
    tick;
    i_req_valid = 1'b0; i_req_addr = 32'hFFF; mem_req_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      chk("bp_mem_req_valid", 32'(mem_req_valid), 32'd1);
      chk("bp_mem_req_addr", mem_req_addr, 32'h400);
      chk("bp_mem_req_typ", 32'(mem_req_typ), 32'h3);
      tick;
    end
    mem_req_ready = 1'b1;
    @(negedge clock);
    chk("bp_c6_mem_req_valid", 32'(mem_req_valid), 32'd1);
    tick;
    @(negedge clock);
    chk("bp_c7_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("bp_c7_i_resp_valid", 32'(i_resp_valid), 32'd1);
    tick;

    // Silent memory: timeout after the WAIT cycle where the timer reads 255.
    mem_auto = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    push(1'b1, 32'h5000, 32'h0, 1'b0, 3'h2, 1'b1, 32'h0);
    d_req_valid = 1'b1; d_req_addr = 32'h5000; d_req_typ = 3'h2;
    @(negedge clock);
    chk("to_d_ready", 32'(d_req_ready), 32'd1);
    tick;
    d_req_valid = 1'b0;
    tick;
    repeat (254) tick;
    @(negedge clock);
    chk("to_j254_d_resp_valid", 32'(d_resp_valid), 32'd0);
    chk("to_j254_timeout_err", 32'(timeout_err), 32'd0);
    tick;
    @(negedge clock);
    chk("to_j255_d_resp_valid", 32'(d_resp_valid), 32'd1);
    chk("to_j255_d_resp_data", d_resp_data, 32'h0);
    tick;
    @(negedge clock);
    chk("to_err_set", 32'(timeout_err), 32'd1);
    chk("to_idle_mem_req_valid", 32'(mem_req_valid), 32'd0);
    tick;
    mem_auto = 1'b1;
    push(1'b0, 32'h500, 32'h0, 1'b0, 3'h3, 1'b1, md(32'h500));
    base = resp_cnt;
    i_req_valid = 1'b1; i_req_addr = 32'h500;
    @(negedge clock);
    chk("to_idle_i_ready", 32'(i_req_ready), 32'd1);
    tick;
    i_req_valid = 1'b0;
    wait_resp(base + 1, 10);
    tick;
    chk("to_err_sticky", 32'(timeout_err), 32'd1);
    tick;

    // Reset while in WAIT_D: outstanding response is dropped.
    mem_auto = 1'b0; mem_resp_valid = 1'b0;
    push(1'b1, 32'h7000, 32'h0, 1'b0, 3'h2, 1'b0, 32'h0);
    d_req_valid = 1'b1; d_req_addr = 32'h7000;
    @(negedge clock);
    chk("rm_d_ready", 32'(d_req_ready), 32'd1);
    tick;
    d_req_valid = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    tick;
    @(negedge clock);
    chk("rm_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rm_mem_req_addr", mem_req_addr, 32'h0);
    chk("rm_mem_req_typ", 32'(mem_req_typ), 32'h0);
    chk("rm_timeout_err", 32'(timeout_err), 32'd0);
    chk("rm_d_resp_valid", 32'(d_resp_valid), 32'd0);
    tick;
    reset = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0BAD0;
    @(negedge clock);
    chk("rm_late_d_resp", 32'(d_resp_valid), 32'd0);
    chk("rm_late_i_resp", 32'(i_resp_valid), 32'd0);
    tick;
    mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    tick;

    // Response exactly in the limit cycle is a normal completion.
    push(1'b1, 32'h6000, 32'h0, 1'b0, 3'h2, 1'b1, 32'h12345678);
    d_req_valid = 1'b1; d_req_addr = 32'h6000;
    @(negedge clock);
    chk("edge_d_ready", 32'(d_req_ready), 32'd1);
    tick;
    d_req_valid = 1'b0;
    tick;
    repeat (255) tick;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h12345678;
    @(negedge clock);
    chk("edge_d_resp_valid", 32'(d_resp_valid), 32'd1);
    chk("edge_d_resp_data", d_resp_data, 32'h12345678);
    tick;
    mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    @(negedge clock);
    chk("edge_no_err", 32'(timeout_err), 32'd0);
    chk("edge_idle_mem_req_valid", 32'(mem_req_valid), 32'd0);
    tick;
    mem_auto = 1'b1;
    repeat (3) tick;

    chk("q_grant_empty", 32'(q_grant.size()), 32'd0);
    chk("q_mreq_empty", 32'(q_mreq.size()), 32'd0);
    chk("q_resp_empty", 32'(q_resp.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
